// File: rtl/bin_to_seg_bcd.sv
// bin_to_seg_bcd: sequential double-dabble binary-to-BCD converter feeding an 8-digit segment driver
module bin_to_seg_bcd #(
  parameter int IN_W     = 27,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] bin_in,
  input  logic [7:0]      dot_in,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic [3:0]      seg_data_1,
  output logic [3:0]      seg_data_2,
  output logic [3:0]      seg_data_3,
  output logic [3:0]      seg_data_4,
  output logic [3:0]      seg_data_5,
  output logic [3:0]      seg_data_6,
  output logic [3:0]      seg_data_7,
  output logic [3:0]      seg_data_8,
  output logic [7:0]      seg_data_en,
  output logic [7:0]      seg_dot_en
);
  localparam int CW = $clog2(IN_W + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t          state_q, state_d;
  logic [IN_W-1:0] bin_q, bin_d, bin_n;
  logic [31:0]     bcd_q, bcd_d, bcd_n, adj, seg_q, seg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      dot_q, dot_d, en_q, en_d, dot_en_q, dot_en_d, lz;
  logic            ovf_q, ovf_d, busy_q, busy_d, done_q, done_d, overflow_q, overflow_d;
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    dot_d      = dot_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    seg_d      = seg_q;
    en_d       = en_q;
    dot_en_d   = dot_en_q;
    for (int i = 0; i < 8; i++)
      adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
    {bcd_n, bin_n} = {adj, bin_q} << 1;
    // enable every digit up to the most significant nonzero one; ones digit always lit
    lz = 8'h01;
    for (int i = 1; i < 8; i++)
      if (bcd_n[4*i+:4] != 4'd0) lz = 8'((9'd1 << (i + 1)) - 9'd1);
    if (state_q == IDLE) begin
      if (start) begin
        state_d = SHIFT;
        bin_d   = bin_in;
        dot_d   = dot_in;
        ovf_d   = 64'(bin_in) > 64'd99_999_999;
        bcd_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    end else begin
      bin_d = bin_n;
      bcd_d = bcd_n;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(IN_W - 1)) begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        overflow_d = ovf_q;
        seg_d      = ovf_q ? 32'h0000_000E : bcd_n;
        en_d       = ovf_q ? 8'h01 : (LZ_BLANK ? lz : 8'hFF);
        dot_en_d   = ovf_q ? 8'h00 : dot_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      dot_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      seg_q      <= '0;
      en_q       <= 8'h01;
      dot_en_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      dot_q      <= dot_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      seg_q      <= seg_d;
      en_q       <= en_d;
      dot_en_q   <= dot_en_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign seg_data_1  = seg_q[3:0];
  assign seg_data_2  = seg_q[7:4];
  assign seg_data_3  = seg_q[11:8];
  assign seg_data_4  = seg_q[15:12];
  assign seg_data_5  = seg_q[19:16];
  assign seg_data_6  = seg_q[23:20];
  assign seg_data_7  = seg_q[27:24];
  assign seg_data_8  = seg_q[31:28];
  assign seg_data_en = en_q;
  assign seg_dot_en  = dot_en_q;
endmodule
